// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first: d = a - b - bin.
// One full-subtractor cell plus a borrow flop; WIDTH clocks per operation.
module serial_subtractor #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, d_q, d_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             x, borrow_nx;

  // Full-subtractor cell on the current LSB
  assign x         = sa_q[0] ^ sb_q[0] ^ borrow_q;
  assign borrow_nx = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & borrow_q) | (sb_q[0] & borrow_q);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    d_d      = d_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = bin;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        sr_d     = {x, sr_q[WIDTH-1:1]};
        borrow_d = borrow_nx;
        count_d  = count_q + CNT_W'(1);
        // Last bit: publish the fully shifted result straight from the cell
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          d_d     = {x, sr_q[WIDTH-1:1]};
          bout_d  = borrow_nx;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): latency, arithmetic,
// ignored start, async reset abort and back-to-back operation.
module tb_serial_subtractor;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, bout;
  logic [7:0] d;

  int n_chk = 0, n_fail = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, wait (bounded) for done, check result, return to IDLE.
  task automatic run_op(input string tag, input logic [7:0] ra, input logic [7:0] rb,
                        input logic rbin, input logic [7:0] ed, input logic eb);
    int k;
    a = ra; b = rb; bin = rbin; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    for (k = 0; k < 20 && !done; k++) step();
    check({tag, " done"}, done, 1);
    check({tag, " d"}, d, ed);
    check({tag, " bout"}, bout, eb);
    step();
    check({tag, " done drop"}, done, 0);
  endtask

  initial begin
    int pulses, k, cyc, last;
    logic [7:0] cap_d;
    logic       cap_b, seen;
    logic [8:0] ref_r;
    logic [7:0] ra, rb, op_a[3], op_b[3], op_d[3];
    logic       rbin, op_bin[3], op_bo[3];

    // Reset state
    #2;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst d", d, 0);
    check("rst bout", bout, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: latency and busy window
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0; a = 8'h00; b = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1 busy c%0d", i), busy, 1);
      check($sformatf("t1 done c%0d", i), done, 0);
      if (i < 7) check($sformatf("t1 d hold c%0d", i), d, 0);
      step();
    end
    check("t1 busy end", busy, 0);
    check("t1 done", done, 1);
    check("t1 d", d, 8'h1E);
    check("t1 bout", bout, 0);
    step();
    check("t1 done drop", done, 0);

    // 2/3: boundary vectors
    run_op("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("t2b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    run_op("t3",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // 3: random vectors against a 9-bit arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      ref_r = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      run_op($sformatf("rnd%0d", i), ra, rb, rbin, ref_r[7:0], ref_r[8]);
    end

    // 4: start during RUN is ignored
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; a = 8'h00;
    step();
    start = 1'b0;
    pulses = 0; cap_d = '0; cap_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin pulses++; cap_d = d; cap_b = bout; end
      step();
    end
    check("t4 pulses", pulses, 1);
    check("t4 d", cap_d, 8'h7F);
    check("t4 bout", cap_b, 0);
    check("t4 idle", busy, 0);

    // 5: async reset on the 4th RUN cycle
    a = 8'h33; b = 8'h11; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("t5 busy pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 busy", busy, 0);
    check("t5 done", done, 0);
    check("t5 d", d, 0);
    check("t5 bout", bout, 0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen |= done;
      step();
    end
    check("t5 no done", seen, 0);
    check("t5 busy idle", busy, 0);
    run_op("t5 new", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

    // 6: start held high, three back-to-back ops
    op_a[0] = 8'h20; op_b[0] = 8'h05; op_bin[0] = 1'b0; op_d[0] = 8'h1B; op_bo[0] = 1'b0;
    op_a[1] = 8'h05; op_b[1] = 8'h20; op_bin[1] = 1'b0; op_d[1] = 8'hE5; op_bo[1] = 1'b1;
    op_a[2] = 8'h77; op_b[2] = 8'h77; op_bin[2] = 1'b1; op_d[2] = 8'hFF; op_bo[2] = 1'b1;
    a = op_a[0]; b = op_b[0]; bin = op_bin[0]; start = 1'b1;
    k = 0; cyc = 0; last = 0;
    for (int c = 0; c < 45 && k < 3; c++) begin
      step();
      cyc++;
      if (done) begin
        check($sformatf("t6 d%0d", k), d, op_d[k]);
        check($sformatf("t6 bout%0d", k), bout, op_bo[k]);
        if (k > 0) check($sformatf("t6 gap%0d", k), cyc - last, 10);
        last = cyc;
        k++;
        if (k < 3) begin a = op_a[k]; b = op_b[k]; bin = op_bin[k]; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    check("t6 ops", k, 3);
    step(); step();
    check("t6 idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
